// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM duty decoder and its neighbours on the dimmer link.
// DUTY_W is the duty-code width agreed with the dimmer side.
package pwm_duty_decoder_pkg;
   localparam int DUTY_W    = 4;
   localparam int DIV_STEPS = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;
endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer with a registered-delay rising-edge detector.
// Also usable for button and encoder inputs.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise
);
   logic meta_q, sync_q, dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~dly_q;
endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time and period of an external PWM line between rising edges and
// recovers duty = floor(16*H/P) with a 4-step restoring divider; flags stuck lines.
module pwm_duty_decoder
   import pwm_duty_decoder_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic [CNT_W-1:0]  high_cycles,
   output logic [CNT_W-1:0]  period_cycles,
   output logic              valid,
   output logic              stuck_high,
   output logic              stuck_low,
   output logic              overrun
);
   localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);
   localparam logic [1:0]       LAST_STEP = 2'(DIV_STEPS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (v >= TO_LIM)  sat_inc = TO_LIM;
      else if (inc)     sat_inc = v + CNT_W'(1);
      else              sat_inc = v;
   endfunction

   logic pwm_s, rise;

   pwm_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (pwm_in),
      .sync_out (pwm_s),
      .rise     (rise)
   );

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  per_q, per_d, hi_q, hi_d;
   logic [CNT_W-1:0]  cap_h_q, cap_h_d, cap_p_q, cap_p_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DUTY_W-1:0] quo_q, quo_d;
   logic [1:0]        step_q, step_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0]  high_q, high_d, period_q, period_d;
   logic              valid_q, valid_d, sth_q, sth_d, stl_q, stl_d, ovr_q, ovr_d;

   // rem < P always, so the doubled remainder needs one extra bit for the compare only
   logic [CNT_W:0]    rem2;
   logic [CNT_W-1:0]  rem_sub;
   logic              ge, timeout_hit;

   assign rem2        = {rem_q, 1'b0};
   assign ge          = rem2 >= {1'b0, cap_p_q};
   assign rem_sub     = rem2[CNT_W-1:0] - cap_p_q;
   assign timeout_hit = (per_q >= TO_LIM) && !sth_q && !stl_q;

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      hi_d     = hi_q;
      cap_h_d  = cap_h_q;
      cap_p_d  = cap_p_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      step_d   = step_q;
      duty_d   = duty_q;
      high_d   = high_q;
      period_d = period_q;
      sth_d    = sth_q;
      stl_d    = stl_q;
      valid_d  = 1'b0;
      ovr_d    = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         per_d   = '0;
         hi_d    = '0;
      end else begin
         if (rise) begin
            per_d = CNT_W'(1);
            hi_d  = CNT_W'(1);
            sth_d = 1'b0;
            stl_d = 1'b0;
         end else begin
            per_d = sat_inc(per_q, 1'b1);
            hi_d  = sat_inc(hi_q, pwm_s);
         end

         case (state_q)
            ST_IDLE, ST_MEAS: begin
               if (rise) begin
                  if (state_q == ST_IDLE) begin
                     state_d = ST_MEAS;
                  end else begin
                     cap_h_d = hi_q;
                     cap_p_d = per_q;
                     rem_d   = hi_q;
                     quo_d   = '0;
                     step_d  = '0;
                     state_d = ST_DIV;
                  end
               end else if (timeout_hit) begin
                  sth_d    = pwm_s;
                  stl_d    = ~pwm_s;
                  duty_d   = pwm_s ? {DUTY_W{1'b1}} : '0;
                  high_d   = '0;
                  period_d = '0;
                  valid_d  = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_DIV: begin
               ovr_d  = rise;
               rem_d  = ge ? rem_sub : rem2[CNT_W-1:0];
               quo_d  = {quo_q[DUTY_W-2:0], ge};
               step_d = step_q + 2'd1;
               if (step_q == LAST_STEP) state_d = ST_DONE;
            end
            ST_DONE: begin
               // four quotient bits cannot exceed 15 because H < P
               ovr_d    = rise;
               duty_d   = quo_q;
               high_d   = cap_h_q;
               period_d = cap_p_q;
               valid_d  = 1'b1;
               state_d  = ST_MEAS;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         per_q    <= '0;
         hi_q     <= '0;
         cap_h_q  <= '0;
         cap_p_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         step_q   <= '0;
         duty_q   <= '0;
         high_q   <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         sth_q    <= 1'b0;
         stl_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         per_q    <= per_d;
         hi_q     <= hi_d;
         cap_h_q  <= cap_h_d;
         cap_p_q  <= cap_p_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         step_q   <= step_d;
         duty_q   <= duty_d;
         high_q   <= high_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         sth_q    <= sth_d;
         stl_q    <= stl_d;
         ovr_q    <= ovr_d;
      end
   end

   assign duty          = duty_q;
   assign high_cycles   = high_q;
   assign period_cycles = period_q;
   assign valid         = valid_q;
   assign stuck_high    = sth_q;
   assign stuck_low     = stl_q;
   assign overrun       = ovr_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: PWM vector table plus stuck, overrun, reset and enable sequences.
module tb_pwm_duty_decoder;
   localparam int CNT_W = 16;
   localparam int TO    = 200;

   logic             clk = 1'b0, rst = 1'b1, en = 1'b0, pwm_in = 1'b0;
   logic [3:0]       duty;
   logic [CNT_W-1:0] high_cycles, period_cycles;
   logic             valid, stuck_high, stuck_low, overrun;

   always #5 clk = ~clk;

   pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .pwm_in        (pwm_in),
      .duty          (duty),
      .high_cycles   (high_cycles),
      .period_cycles (period_cycles),
      .valid         (valid),
      .stuck_high    (stuck_high),
      .stuck_low     (stuck_low),
      .overrun       (overrun)
   );

   typedef struct { int per; int hi; int duty; } vec_t;
   typedef struct {
      logic [3:0]       duty;
      logic [CNT_W-1:0] hi;
      logic [CNT_W-1:0] per;
      logic             sth;
      logic             stl;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ovr_cnt = 0;
   vec_t vecs[23];

   function automatic void chk(string nm, longint act, longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int d, input int h, input int p, input bit sh, input bit sl);
      exp_t e;
      e.duty = 4'(d); e.hi = CNT_W'(h); e.per = CNT_W'(p); e.sth = sh; e.stl = sl;
      sb.push_back(e);
   endtask

   task automatic drive(input int p, input int h, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = 1'b1; cyc(h);
         pwm_in = 1'b0; cyc(p - h);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic wait_empty(input int budget, input string nm);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d results still pending, expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      vecs[0]  = '{32, 8, 4};
      for (int w = 1; w <= 15; w++) vecs[w] = '{16, w, w};
      vecs[16] = '{6, 5, 13};
      vecs[17] = '{7, 3, 6};
      vecs[18] = '{100, 33, 5};
      vecs[19] = '{6, 1, 2};
      vecs[20] = '{50, 49, 15};
      vecs[21] = '{9, 1, 1};
      vecs[22] = '{20, 10, 8};

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (overrun) ovr_cnt++;
            if (valid) begin
               if (sb.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_valid: got valid with duty=%0d H=%0d P=%0d, expected no valid",
                           duty, high_cycles, period_cycles);
               end else begin
                  e = sb.pop_front();
                  chk("valid_duty", duty, e.duty);
                  chk("valid_high", high_cycles, e.hi);
                  chk("valid_period", period_cycles, e.per);
                  chk("valid_stuck_high", stuck_high, e.sth);
                  chk("valid_stuck_low", stuck_low, e.stl);
               end
            end
         end
      join_none

      // reset state
      cyc(3);
      chk("rst_duty", duty, 0);
      chk("rst_high", high_cycles, 0);
      chk("rst_period", period_cycles, 0);
      chk("rst_valid", valid, 0);
      chk("rst_stuck_high", stuck_high, 0);
      chk("rst_stuck_low", stuck_low, 0);
      chk("rst_overrun", overrun, 0);

      // table: each vector arms on the first rise, then captures three periods
      for (int i = 0; i < 23; i++) begin
         do_reset();
         en = 1'b1; ovr_cnt = 0;
         for (int k = 0; k < 3; k++) push(vecs[i].duty, vecs[i].hi, vecs[i].per, 1'b0, 1'b0);
         drive(vecs[i].per, vecs[i].hi, 4);
         cyc(12);
         wait_empty(20, "vec_pending");
         chk("vec_no_overrun", ovr_cnt, 0);
      end

      // stuck low from reset: one valid, then silence
      do_reset();
      en = 1'b1;
      push(0, 0, 0, 1'b0, 1'b1);
      wait_empty(TO + 100, "stuck_low_pending");
      cyc(TO + 50);
      chk("stuck_low_level", stuck_low, 1);
      chk("stuck_low_duty", duty, 0);

      // stuck high after a rise; next rise clears and only arms
      do_reset();
      en = 1'b1;
      push(8, 10, 20, 1'b0, 1'b0);
      push(15, 0, 0, 1'b1, 1'b0);
      drive(20, 10, 1);
      pwm_in = 1'b1;
      wait_empty(TO + 100, "stuck_high_pending");
      cyc(20);
      chk("stuck_high_level", stuck_high, 1);
      chk("stuck_high_duty", duty, 15);
      pwm_in = 1'b0; cyc(10);
      pwm_in = 1'b1; cyc(5);
      chk("stuck_high_cleared", stuck_high, 0);
      pwm_in = 1'b0; cyc(5);
      push(8, 5, 10, 1'b0, 1'b0);
      drive(10, 5, 1);
      cyc(10);
      wait_empty(20, "stuck_high_rearm");

      // period 4: every other rise lands in DIV and is dropped
      do_reset();
      en = 1'b1; ovr_cnt = 0;
      for (int k = 0; k < 6; k++) push(8, 2, 4, 1'b0, 1'b0);
      drive(4, 2, 12);
      cyc(12);
      wait_empty(20, "overrun_pending");
      chk("overrun_count", ovr_cnt, 5);

      // reset while the divider is running
      do_reset();
      en = 1'b1;
      push(8, 10, 20, 1'b0, 1'b0);
      drive(20, 10, 2);
      wait_empty(5, "pre_reset_pending");
      pwm_in = 1'b1;
      cyc(3);
      rst = 1'b1; pwm_in = 1'b0;
      cyc(1);
      chk("midrst_duty", duty, 0);
      chk("midrst_high", high_cycles, 0);
      chk("midrst_period", period_cycles, 0);
      chk("midrst_valid", valid, 0);
      rst = 1'b0;
      push(6, 8, 20, 1'b0, 1'b0);
      drive(20, 8, 2);
      cyc(12);
      wait_empty(20, "post_reset_pending");

      // enable dropped mid-stream: outputs hold, re-arm on return
      do_reset();
      en = 1'b1;
      push(4, 5, 20, 1'b0, 1'b0);
      push(4, 5, 20, 1'b0, 1'b0);
      drive(20, 5, 3);
      cyc(12);
      wait_empty(20, "en_pre_pending");
      en = 1'b0;
      drive(10, 5, 5);
      chk("en_hold_duty", duty, 4);
      chk("en_hold_high", high_cycles, 5);
      chk("en_hold_period", period_cycles, 20);
      en = 1'b1;
      push(6, 10, 25, 1'b0, 1'b0);
      push(6, 10, 25, 1'b0, 1'b0);
      drive(25, 10, 3);
      cyc(12);
      wait_empty(20, "en_post_pending");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive side of the LED dimmer PWM link: samples an external PWM waveform, such as the led_dimmer pwm output, and recovers its 4-bit duty code.
- Measures high time and period in clk cycles and computes duty = floor(16*H/P) with a 4-cycle sequential divider.
- Flags stuck-high/stuck-low lines and dropped samples.
- Sits next to the dimmer for loopback self-check or drives a duty readout.

Parameters:
- CNT_W, 16, width of the period/high-time counters and outputs.
- TIMEOUT, 65535, cycles without a rising edge before the line is declared stuck; must be ≤ 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  measurement enable.
- pwm_in  input  1  asynchronous PWM line.
- duty  output  4  recovered duty code, 0..15.
- high_cycles  output  CNT_W  last captured high time H.
- period_cycles  output  CNT_W  last captured period P.
- valid  output  1  one-cycle pulse when duty, high_cycles and period_cycles update.
- stuck_high  output  1  level; line high for TIMEOUT cycles.
- stuck_low  output  1  level; line low for TIMEOUT cycles.
- overrun  output  1  one-cycle pulse; an edge was dropped because the divider was busy.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronizer flops 0.
- Synchronizer and edge detect:
  - 2-FF synchronizer produces pwm_s; pwm_d is pwm_s delayed one cycle.
  - rise = pwm_s & ~pwm_d. Falling edges are not used.
- Counters, in every state while en=1:
  - On a rise cycle: per_cnt<=1, hi_cnt<=1.
  - Otherwise: per_cnt<=per_cnt+1 and hi_cnt<=hi_cnt+pwm_s, both saturating at TIMEOUT.
  - At a rise, per_cnt holds P (cycles between consecutive rises) and hi_cnt holds H (high cycles in that period). H<P always holds.
- FSM states IDLE, MEAS, DIV, DONE:
  - IDLE: wait for a rise. On rise go to MEAS. This first edge arms only; no capture.
  - MEAS: on rise, capture H,P into cap_h,cap_p; rem<=H; q<=0; go to DIV.
  - DIV: runs exactly 4 cycles, restoring division MSB first. Each cycle: rem2=rem<<1; if rem2>=cap_p then rem<=rem2-cap_p and q bit=1, else rem<=rem2 and q bit=0. Then go to DONE.
  - DONE: for 1 cycle; duty<=min(q,15), high_cycles<=cap_h, period_cycles<=cap_p, valid=1 on the next cycle; go to MEAS.
  - Latency: valid is high exactly 5 cycles after the capture edge.
- Edge while busy: a rise in DIV or DONE still restarts the counters. That sample is not captured, overrun pulses for 1 cycle, and the FSM is unaffected. Minimum loss-free period is P≥6.
- Timeout: per_cnt reaching TIMEOUT in MEAS or IDLE does the following, all at once:
  - if pwm_s=1: stuck_high<=1, duty<=15;
  - if pwm_s=0: stuck_low<=1, duty<=0;
  - valid pulses once, high_cycles/period_cycles<=0, FSM goes to IDLE.
  - No further valid pulses until re-armed.
- Stuck flags clear on the next rise.
- en=0:
  - FSM forced to IDLE, counters cleared, no valid/overrun pulses.
  - Outputs hold their last values; stuck flags hold.
  - The synchronizer keeps running.
- Reset mid-operation (any state) returns everything to reset values in one cycle. Re-arming needs 2 rises before the first valid.
- Widths: all compares are CNT_W+1 bits wide (rem2 can reach 2P-2). Quotient is at most 15 because H<P.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=0, MEAS=1, DIV=2, DONE=3), DUTY_W=4, DIV_STEPS=4. The dimmer and any duty consumer share DUTY_W.
- One sub-module, pwm_sync_edge (clk, rst, async_in → sync_out, rise): the 2-FF synchronizer plus rise detector, reusable for button/encoder inputs.

Test Plan:
- Reset then en=1; pwm_in period 32 cycles, high 8 → after 2nd rise, valid with duty=4, high_cycles=8, period_cycles=32; repeats every 32 cycles.
- Sweep an led_dimmer-style source with period 16, high w=1..15 → duty=w each time. w=0 (line held low) → after TIMEOUT cycles: stuck_low=1, duty=0, single valid pulse.
- pwm_in held high after a rise → TIMEOUT cycles later: stuck_high=1, duty=15, valid once. Next rise clears stuck_high; no valid until the following rise.
- Period 4, high 2 → overrun pulses on the rises that land in DIV/DONE. Valid results that do appear report duty=8, P=4, H=2.
- rst asserted in the middle of DIV → next cycle all outputs 0, FSM IDLE. The first valid after reset needs two further rises.
- en dropped for 50 cycles mid-stream → no valid while low, outputs hold. After en returns, the first valid comes on the second rise.
